// File: rtl/frame_crc_check_if.sv
// Payload stream from the CRC check stage to its consumer.
// Byte plus last marker, moved on valid & ready.
interface frame_crc_check_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/frame_crc_check.sv
// Frame stage after the PN9 de-whitener: header capture, payload
// FIFO with last marking, CRC-16/CCITT-FALSE check, status pulse.
module frame_crc_check #(
    parameter int FIFO_DEPTH = 64,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic [1:0]       in_code,
    input  logic             in_end,
    frame_crc_check_if.master m,
    output logic [7:0]       hdr_len,
    output logic             hdr_valid,
    output logic             stat_valid,
    output logic             stat_crc_ok,
    output logic             stat_overflow,
    output logic             stat_proto_err,
    output logic [LVL_W-1:0] fifo_level
);
    localparam int PTR_W = LVL_W - 1;

    typedef enum logic [2:0] {IDLE, HDR, PAY, FCS1, DONE} state_t;

    state_t state, state_nx;

    logic strobe, c_hdr, c_pay, c_fcs;
    logic start, crc_upd, pend_load, push, push_last;
    logic fcs_hi, finish, abort;

    logic [15:0] crc;
    logic [7:0]  rx_hi;
    logic [7:0]  pend_data;
    logic        pend_valid;
    logic        wr_en;
    logic [8:0]  wr_data;
    logic        ovf;

    logic [8:0]       mem [FIFO_DEPTH];
    logic [LVL_W-1:0] wr_ptr, rd_ptr;
    logic             full, pop, wr_ok, drop;

    assign strobe = in_code != 2'd0;
    assign c_hdr  = in_code == 2'd1;
    assign c_pay  = in_code == 2'd2;
    assign c_fcs  = in_code == 2'd3;

    // One payload byte folded into the CRC, MSB first.
    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: only strobes move the FSM, except DONE which lasts one cycle.
    always_comb begin
        state_nx = state;
        if (state == DONE) state_nx = IDLE;
        if (strobe) begin
            unique case (state)
                HDR, PAY: begin
                    if (in_end)     state_nx = IDLE;
                    else if (c_pay) state_nx = PAY;
                    else if (c_fcs) state_nx = FCS1;
                    else            state_nx = HDR;
                end
                FCS1: state_nx = (c_fcs && in_end) ? DONE : IDLE;
                default: if (c_hdr && !in_end) state_nx = HDR;
            endcase
        end
    end

    // Per-strobe actions; an abort flushes the pending byte as last.
    always_comb begin
        start     = 1'b0;
        crc_upd   = 1'b0;
        pend_load = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        fcs_hi    = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        if (strobe) begin
            unique case (state)
                HDR, PAY: begin
                    if (in_end) begin
                        abort = 1'b1;
                    end else if (c_pay) begin
                        crc_upd   = 1'b1;
                        pend_load = 1'b1;
                        push      = pend_valid;
                    end else if (c_fcs) begin
                        fcs_hi    = 1'b1;
                        push      = pend_valid;
                        push_last = 1'b1;
                    end else if (state == PAY) begin
                        abort = 1'b1;
                        start = 1'b1;
                    end
                end
                FCS1: begin
                    if (c_fcs && in_end) finish = 1'b1;
                    else                 abort  = 1'b1;
                end
                default: begin
                    if (c_hdr) begin
                        start = 1'b1;
                        abort = in_end;
                    end
                end
            endcase
            if (abort) begin
                push      = pend_valid;
                push_last = 1'b1;
            end
        end
    end

    // Header capture, CRC accumulation and received FCS high byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_len   <= 8'd0;
            hdr_valid <= 1'b0;
            crc       <= 16'hFFFF;
            rx_hi     <= 8'd0;
        end else begin
            hdr_valid <= start;
            if (start) begin
                hdr_len <= in_data;
                crc     <= 16'hFFFF;
            end else if (crc_upd) begin
                crc <= crc_step(crc, in_data);
            end
            if (fcs_hi) rx_hi <= in_data;
        end
    end

    // One-byte pending register delays each byte until its successor decides last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data  <= 8'd0;
            pend_valid <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= 9'd0;
        end else begin
            wr_en   <= push;
            wr_data <= {push_last, pend_data};
            if (pend_load) begin
                pend_data  <= in_data;
                pend_valid <= 1'b1;
            end else if (push) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Frame flags and the registered status pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf            <= 1'b0;
            stat_valid     <= 1'b0;
            stat_crc_ok    <= 1'b0;
            stat_overflow  <= 1'b0;
            stat_proto_err <= 1'b0;
        end else begin
            if (start)     ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
            stat_valid     <= finish | abort;
            stat_crc_ok    <= finish & ({rx_hi, in_data} == crc);
            stat_overflow  <= (finish | abort) & (ovf | drop);
            stat_proto_err <= abort;
        end
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = fifo_level == LVL_W'(FIFO_DEPTH);
    assign pop        = m.valid & m.ready;
    assign wr_ok      = wr_en & (~full | pop);
    assign drop       = wr_en & full & ~pop;
    assign m.valid    = fifo_level != '0;
    assign m.data     = m.valid ? mem[rd_ptr[PTR_W-1:0]][7:0] : 8'd0;
    assign m.last     = m.valid ? mem[rd_ptr[PTR_W-1:0]][8] : 1'b0;

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end

    // FIFO pointers with one extra wrap bit so the level covers full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule
